uart_rx_param: RTL and testbench

Parametrised UART receiver that replaces the fixed 8N1 receive path feeding the 7-segment display logic. It provides configurable data width, parity, stop bits and bit period, plus a 2-flop input synchroniser and sticky error flags. Received characters go into a small first-word-fall-through FIFO with a valid/ready read port, so the display decoder can consume bytes at its own pace.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit paths: parity modes,
// receiver state encoding and a width helper for counters and pointers.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_t;

    // Ceiling log2, minimum 1 so a counter always has at least one bit.
    function automatic int uart_clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rd_data whenever empty=0; rd_en pops it. A write while full is accepted
// only if a pop happens in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = uart_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_rd;
    logic w_wr;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_rd    = rd_en && !empty;
    assign w_wr    = wr_en && (!full || w_rd);
    // Hold rd_data at zero while empty so the port has a defined reset value.
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wr_data;
    end

    // Pointers and occupancy count; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
            if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, start/data/parity/stop
// FSM with a mid-bit sampling timer, sticky error flags and an FWFT
// receive FIFO with a valid/ready read port.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 err_clr
);

    localparam int TMR_W = uart_clog2(CLKS_PER_BIT);
    localparam int IDX_W = uart_clog2(DATA_BITS + 1);

    localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_FULL  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_q;
    rx_state_t            r_state;
    logic [TMR_W-1:0]     r_tmr;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bad;
    logic                 r_stop_bad;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overflow;

    logic w_sample;
    logic w_par_x;
    logic w_stop_bad_now;
    logic w_frame_done;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign w_sample       = (r_tmr == TMR_FULL);
    assign w_par_x        = (^r_shift) ^ r_rx_s;
    // Stop sample being taken this cycle counts together with earlier ones.
    assign w_stop_bad_now = r_stop_bad | ~r_rx_s;
    assign w_frame_done   = (r_state == ST_STOP) && w_sample && (r_idx == LAST_STOP);
    assign w_push         = w_frame_done && !r_par_bad && !w_stop_bad_now;
    assign w_pop          = rd_valid && rd_ready;
    // A pop in the same cycle frees a slot, so only a full FIFO without pop drops.
    assign w_drop         = w_push && w_full && !w_pop;

    assign rd_valid   = ~w_empty;
    assign busy       = (r_state != ST_IDLE);
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_q    <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_q    <= r_rx_s;
        end
    end

    // Frame FSM: bit timer, bit index, shift register and per-frame error bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmr      <= '0;
                    r_idx      <= '0;
                    r_par_bad  <= 1'b0;
                    r_stop_bad <= 1'b0;
                    // Edge, not level: a line stuck low cannot retrigger.
                    if (r_rx_q && !r_rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    if (r_tmr == TMR_HALF) begin
                        r_tmr   <= '0;
                        r_state <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_tmr   <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == LAST_DATA) begin
                            r_idx   <= '0;
                            r_state <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_PAR: begin
                    if (w_sample) begin
                        r_tmr     <= '0;
                        r_par_bad <= (PARITY == PARITY_EVEN) ? w_par_x : ~w_par_x;
                        r_state   <= ST_STOP;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_tmr      <= '0;
                        r_stop_bad <= w_stop_bad_now;
                        if (r_idx == LAST_STOP) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_parity_err <= (r_parity_err & ~err_clr) | (w_frame_done & r_par_bad);
            r_frame_err  <= (r_frame_err  & ~err_clr) | (w_frame_done & w_stop_bad_now);
            r_overflow   <= (r_overflow   & ~err_clr) | w_drop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (r_shift),
        .rd_en   (rd_ready),
        .rd_data (rd_data),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 instance (a) and one even-parity
// instance (b). Expected characters are queued when a frame is sent and
// popped by a monitor whenever the DUT hands a character over.
module tb_uart_rx_param;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rd_ready_a, err_clr_a;
    logic [7:0] rd_data_a;
    logic       rd_valid_a, busy_a, parity_err_a, frame_err_a, overflow_a;
    logic       rx_b, rd_ready_b, err_clr_b;
    logic [7:0] rd_data_b;
    logic       rd_valid_b, busy_b, parity_err_b, frame_err_b, overflow_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .uart_rx(rx_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .rd_ready(rd_ready_a), .busy(busy_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
        .overflow(overflow_a), .err_clr(err_clr_a));

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .uart_rx(rx_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .rd_ready(rd_ready_b), .busy(busy_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
        .overflow(overflow_b), .err_clr(err_clr_b));

    // Scoreboard monitors: a transfer happens on the next edge when valid & ready.
    initial forever begin
        @(negedge clk);
        if (rd_valid_a && rd_ready_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++; $display("FAIL a_unexpected_char got=%02h want=none", rd_data_a);
            end else begin
                logic [7:0] exp_a;
                exp_a = qa.pop_front();
                if (rd_data_a !== exp_a) begin
                    bad++; $display("FAIL a_rd_data got=%02h want=%02h", rd_data_a, exp_a);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rd_valid_b && rd_ready_b) begin
            total++;
            if (qb.size() == 0) begin
                bad++; $display("FAIL b_unexpected_char got=%02h want=none", rd_data_b);
            end else begin
                logic [7:0] exp_b;
                exp_b = qb.pop_front();
                if (rd_data_b !== exp_b) begin
                    bad++; $display("FAIL b_rd_data got=%02h want=%02h", rd_data_b, exp_b);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v; else rx_a = v;
        step(CPB);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit use_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i]);
        if (use_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b want=0", rd_valid_a); end
        total++; if (rd_data_a !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%02h want=00", rd_data_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
        total++; if ({parity_err_a, frame_err_a, overflow_a} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%03b want=000", {parity_err_a, frame_err_a, overflow_a}); end
        total++; if ({rd_valid_b, busy_b, parity_err_b, frame_err_b, overflow_b} !== 5'b0) begin
            bad++; $display("FAIL reset_b_outputs got=%05b want=00000",
                            {rd_valid_b, busy_b, parity_err_b, frame_err_b, overflow_b}); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_8n1;
        int c0, lat;
        rd_ready_a = 1'b0;
        lat = -1;
        c0  = cyc;
        qa.push_back(8'h61);
        fork
            send_frame(1'b0, 8'h61, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (rd_valid_a) begin lat = cyc - c0; break; end
                end
            end
        join
        // 3 + CPB/2 + 9*CPB = 79 cycles from the start-bit pin edge.
        total++; if (lat < 78 || lat > 80) begin bad++; $display("FAIL 8n1_latency got=%0d want=79+-1", lat); end
        total++; if ({parity_err_a, frame_err_a, overflow_a} !== 3'b000) begin
            bad++; $display("FAIL 8n1_flags got=%03b want=000", {parity_err_a, frame_err_a, overflow_a}); end
        step(3);
        total++; if (rd_data_a !== 8'h61) begin bad++; $display("FAIL 8n1_data_stable got=%02h want=61", rd_data_a); end
        rd_ready_a = 1'b1;
        step(2);
        rd_ready_a = 1'b0;
        total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL 8n1_drained got=%0b want=0", rd_valid_a); end
    endtask

    task automatic test_parity;
        rd_ready_b = 1'b0;
        send_frame(1'b1, 8'h61, 1'b1, 1'b0, 1'b1);
        step(4);
        total++; if (parity_err_b !== 1'b1) begin bad++; $display("FAIL par_err_set got=%0b want=1", parity_err_b); end
        total++; if (rd_valid_b !== 1'b0) begin bad++; $display("FAIL par_no_push got=%0b want=0", rd_valid_b); end
        total++; if (frame_err_b !== 1'b0) begin bad++; $display("FAIL par_frame_err got=%0b want=0", frame_err_b); end
        qb.push_back(8'h61);
        send_frame(1'b1, 8'h61, 1'b1, ^8'h61, 1'b1);
        step(4);
        total++; if (rd_valid_b !== 1'b1) begin bad++; $display("FAIL par_good_push got=%0b want=1", rd_valid_b); end
        rd_ready_b = 1'b1;
        step(2);
        rd_ready_b = 1'b0;
        err_clr_b = 1'b1;
        step(1);
        err_clr_b = 1'b0;
        total++; if (parity_err_b !== 1'b0) begin bad++; $display("FAIL par_err_clr got=%0b want=0", parity_err_b); end
    endtask

    task automatic test_frame_err;
        bit seen_busy;
        rd_ready_a = 1'b0;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        seen_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_a) seen_busy = 1'b1;
        end
        step(1);
        total++; if (frame_err_a !== 1'b1) begin bad++; $display("FAIL ferr_set got=%0b want=1", frame_err_a); end
        total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL ferr_no_push got=%0b want=0", rd_valid_a); end
        total++; if (seen_busy !== 1'b0) begin bad++; $display("FAIL ferr_low_retrigger got=%0b want=0", seen_busy); end
        rx_a = 1'b1;
        step(16);
        qa.push_back(8'h3C);
        rd_ready_a = 1'b1;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        step(4);
        rd_ready_a = 1'b0;
        total++; if (qa.size() != 0) begin bad++; $display("FAIL ferr_recover_pending got=%0d want=0", qa.size()); end
        total++; if (frame_err_a !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%0b want=1", frame_err_a); end
        err_clr_a = 1'b1;
        step(1);
        err_clr_a = 1'b0;
        total++; if (frame_err_a !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%0b want=0", frame_err_a); end
    endtask

    task automatic test_glitch;
        bit seen_busy;
        rx_a = 1'b0;
        step(2);
        rx_a = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) seen_busy = 1'b1;
        end
        step(1);
        total++; if (seen_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse got=%0b want=1", seen_busy); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%0b want=0", busy_a); end
        total++; if ({rd_valid_a, parity_err_a, frame_err_a, overflow_a} !== 4'b0000) begin
            bad++; $display("FAIL glitch_no_effect got=%04b want=0000",
                            {rd_valid_a, parity_err_a, frame_err_a, overflow_a}); end
    endtask

    task automatic test_overflow;
        rd_ready_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] d;
            d = 8'(i);
            qa.push_back(d);
            send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
        end
        step(4);
        total++; if (overflow_a !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b want=0", overflow_a); end
        send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        step(4);
        total++; if (overflow_a !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow_a); end
        rd_ready_a = 1'b1;
        step(12);
        rd_ready_a = 1'b0;
        total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid got=%0b want=0", rd_valid_a); end
        total++; if (qa.size() != 0) begin bad++; $display("FAIL ovf_drain_count got=%0d want=0", qa.size()); end
        err_clr_a = 1'b1;
        step(1);
        err_clr_a = 1'b0;
        total++; if (overflow_a !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", overflow_a); end
    endtask

    task automatic test_back_to_back;
        rd_ready_a = 1'b1;
        qa.push_back(8'hA5);
        qa.push_back(8'h5A);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        step(4);
        rd_ready_a = 1'b0;
        total++; if (qa.size() != 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", qa.size()); end
        total++; if ({parity_err_a, frame_err_a, overflow_a} !== 3'b000) begin
            bad++; $display("FAIL b2b_flags got=%03b want=000", {parity_err_a, frame_err_a, overflow_a}); end
    endtask

    task automatic test_reset_mid;
        rd_ready_a = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        step(2);
        total++; if (rd_valid_a !== 1'b1) begin bad++; $display("FAIL rstmid_prefill got=%0b want=1", rd_valid_a); end
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL rstmid_in_frame got=%0b want=1", busy_a); end
        rst = 1'b1;
        step(1);
        total++; if ({rd_valid_a, busy_a, parity_err_a, frame_err_a, overflow_a} !== 5'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%05b want=00000",
                            {rd_valid_a, busy_a, parity_err_a, frame_err_a, overflow_a}); end
        total++; if (rd_data_a !== 8'h00) begin bad++; $display("FAIL rstmid_rd_data got=%02h want=00", rd_data_a); end
        rst = 1'b0;
        rx_a = 1'b1;
        step(16);
        qa.push_back(8'h7E);
        rd_ready_a = 1'b1;
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        step(4);
        rd_ready_a = 1'b0;
        total++; if (qa.size() != 0) begin bad++; $display("FAIL rstmid_recover got=%0d want=0", qa.size()); end
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1; rd_ready_a = 1'b0; err_clr_a = 1'b0;
        rx_b = 1'b1; rd_ready_b = 1'b0; err_clr_b = 1'b0;
        step(1);
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        total++; if (qb.size() != 0) begin bad++; $display("FAIL b_queue_left got=%0d want=0", qb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
